// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared definitions for the memory fill stage and the
// accumulator datapath that consumes the filled memory.
//   - DW_DEFAULT / AW_DEFAULT : default data and address widths
//   - state_e                 : loader FSM state encoding
package mem_loader_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int AW_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    LAUNCH   = 2'd2,
    WAIT_ACC = 2'd3
  } state_e;

endpackage

// File: rtl/wr_addr_counter.sv
// wr_addr_counter: AW-bit write address counter for the memory loader.
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-low reset, clears count
//   clr   in   clear count to 0 (frame start)
//   inc   in   advance by one; wraps to 0 after the terminal count
//   count out  current address
//   tc    out  count equals NUM_WORDS-1 (last word of the frame)
module wr_addr_counter
  import mem_loader_pkg::*;
#(
  parameter int AW        = AW_DEFAULT,
  parameter int NUM_WORDS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] count,
  output logic          tc
);

  localparam logic [AW-1:0] LAST = AW'(NUM_WORDS - 1);

  logic [AW-1:0] count_reg;

  assign count = count_reg;
  assign tc    = (count_reg == LAST);

  // Explicit wrap at the terminal count so frames shorter than 2**AW
  // still restart at address 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= tc ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// mem_loader: fills NUM_WORDS consecutive memory words from a valid/ready
// stream, then launches the accumulator controller and holds off until done.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   start               frame request, honoured only in IDLE
//   in_valid/in_data    input stream; in_ready = loader accepts this cycle
//   mem_we/mem_addr/mem_wdata  memory write port (owned while mem_sel=1)
//   mem_sel             1 = loader drives the memory port
//   go                  one-cycle launch pulse to accumulator controller
//   acc_done            completion from accumulator controller
//   busy                high in every state except IDLE
//   frame_cnt           completed frames, wraps 255->0
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int DW        = DW_DEFAULT,
  parameter int AW        = AW_DEFAULT,
  parameter int NUM_WORDS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_sel,
  output logic          go,
  input  logic          acc_done,
  output logic          busy,
  output logic [7:0]    frame_cnt
);

  state_e        state_reg;
  logic [AW-1:0] wr_addr;
  logic          wr_last;
  logic          beat;
  logic          addr_clr;

  assign beat     = in_valid & in_ready;
  assign addr_clr = (state_reg == IDLE) & start;

  wr_addr_counter #(
    .AW       (AW),
    .NUM_WORDS(NUM_WORDS)
  ) u_wr_addr (
    .clk  (clk),
    .rst  (rst),
    .clr  (addr_clr),
    .inc  (beat),
    .count(wr_addr),
    .tc   (wr_last)
  );

  // The write strobe follows the handshake in the same cycle; in_ready is
  // only high while mem_sel is high, so mem_we can never fire without it.
  // Address and data are zeroed when the accumulator owns the port.
  assign mem_we    = beat;
  assign mem_addr  = mem_sel ? wr_addr : '0;
  assign mem_wdata = mem_sel ? in_data : '0;

  // Outputs are registered alongside the state so each one changes on the
  // same edge as the state it belongs to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      in_ready  <= 1'b0;
      mem_sel   <= 1'b0;
      go        <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= FILL;
            in_ready  <= 1'b1;
            mem_sel   <= 1'b1;
            busy      <= 1'b1;
          end
        end
        FILL: begin
          if (beat && wr_last) begin
            state_reg <= LAUNCH;
            in_ready  <= 1'b0;
            mem_sel   <= 1'b0;
            go        <= 1'b1;
          end
        end
        LAUNCH: begin
          // acc_done is not looked at here: it only counts after go.
          state_reg <= WAIT_ACC;
          go        <= 1'b0;
        end
        WAIT_ACC: begin
          if (acc_done) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b0;
          mem_sel   <= 1'b0;
          go        <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
